// File: rtl/snake_pkg.sv
//------------------------------------------------------------------
// snake_pkg: shared game-status codes, spawner FSM states, LFSR taps.
// Rev 1.0
//------------------------------------------------------------------
`default_nettype none

package snake_pkg;

  localparam logic [1:0] GS_LAUNCHING    = 2'b00;
  localparam logic [1:0] GS_PLAYING      = 2'b01;
  localparam logic [1:0] GS_DIE_FLASHING = 2'b10;
  localparam logic [1:0] GS_INITIALIZING = 2'b11;

  // Galois right-shift mask for x^16+x^14+x^13+x^11+1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRAW   = 3'd1,
    ST_QUERY  = 3'd2,
`ifdef APPLE_SPAWNER_SCAN_EN
    ST_SCAN   = 3'd3,
`endif
    ST_COMMIT = 3'd4
  } spawn_state_e;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/lfsr16.sv
//------------------------------------------------------------------
// lfsr16: free-running 16-bit Galois LFSR with synchronous seed load.
// Rev 1.0
//------------------------------------------------------------------
`default_nettype none

module lfsr16
  import snake_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        load,
  input  logic [15:0] seed,
  output logic [15:0] state
);

  always_ff @(posedge clock) begin
    if (!reset_n || load) begin
      state <= seed;
    end else begin
      state <= lfsr_next(state);
    end
  end

endmodule

`default_nettype wire

// File: rtl/apple_spawner.sv
//------------------------------------------------------------------
// apple_spawner: places apples on free cells via LFSR draws and an
// occupancy handshake. Optional scan fallback: APPLE_SPAWNER_SCAN_EN.
// Rev 1.0
//------------------------------------------------------------------
`default_nettype none

module apple_spawner
  import snake_pkg::*;
#(
  parameter int          X_BITS    = 6,
  parameter int          Y_BITS    = 5,
  parameter int          X_MAX     = 46,
  parameter int          Y_MAX     = 25,
  parameter int          INIT_X    = 20,
  parameter int          INIT_Y    = 13,
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int          MAX_TRIES = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [1:0]        game_status,
  input  logic              get_apple,
  output logic              query_valid,
  output logic [X_BITS-1:0] query_x,
  output logic [Y_BITS-1:0] query_y,
  input  logic              occ_valid,
  input  logic              occupied,
  output logic [X_BITS-1:0] apple_x,
  output logic [Y_BITS-1:0] apple_y,
  output logic              apple_valid,
  output logic              busy,
  output logic              board_full
);

  localparam int TRY_W = $clog2(MAX_TRIES + 1);
`ifdef APPLE_SPAWNER_SCAN_EN
  localparam int CELLS  = X_MAX * Y_MAX;
  localparam int SCAN_W = $clog2(CELLS + 1);
`endif

  logic [15:0]       lfsr;
  logic              lfsr_load;
  logic              unused_lfsr_bits;
  logic [X_BITS:0]   rx_full;
  logic [Y_BITS:0]   ry_full;
  logic [X_BITS-1:0] cand_x;
  logic [Y_BITS-1:0] cand_y;

  spawn_state_e      state_q;
  logic              busy_q;
  logic              query_valid_q;
  logic [X_BITS-1:0] query_x_q;
  logic [Y_BITS-1:0] query_y_q;
  logic [X_BITS-1:0] apple_x_q;
  logic [Y_BITS-1:0] apple_y_q;
  logic              apple_valid_q;
  logic              board_full_q;
  logic [TRY_W-1:0]  tries_q;
`ifdef APPLE_SPAWNER_SCAN_EN
  logic [SCAN_W-1:0] scan_q;
`endif

  assign lfsr_load = (game_status == GS_INITIALIZING);

  lfsr16 u_lfsr (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (lfsr_load),
    .seed    (SEED),
    .state   (lfsr)
  );

  // Only a slice of the LFSR feeds the reduction; the rest is intentionally dropped.
  assign unused_lfsr_bits = ^lfsr;

  always_comb begin
    rx_full = {1'b0, lfsr[X_BITS-1:0]} + (X_BITS+1)'(1);
    if (rx_full > (X_BITS+1)'(X_MAX)) rx_full = rx_full - (X_BITS+1)'(X_MAX);
    ry_full = {1'b0, lfsr[8+Y_BITS-1:8]} + (Y_BITS+1)'(1);
    if (ry_full > (Y_BITS+1)'(Y_MAX)) ry_full = ry_full - (Y_BITS+1)'(Y_MAX);
  end

  assign cand_x = rx_full[X_BITS-1:0];
  assign cand_y = ry_full[Y_BITS-1:0];

  always_ff @(posedge clock) begin
    if (!reset_n || game_status == GS_INITIALIZING) begin
      state_q       <= ST_IDLE;
      busy_q        <= 1'b0;
      query_valid_q <= 1'b0;
      apple_x_q     <= X_BITS'(INIT_X);
      apple_y_q     <= Y_BITS'(INIT_Y);
      apple_valid_q <= 1'b1;
      board_full_q  <= 1'b0;
      tries_q       <= '0;
`ifdef APPLE_SPAWNER_SCAN_EN
      scan_q        <= '0;
`endif
      // Query coordinates only clear on a true reset; INITIALIZING just drops the strobe.
      if (!reset_n) begin
        query_x_q <= '0;
        query_y_q <= '0;
      end
    end else if (busy_q && (game_status == GS_LAUNCHING ||
                            game_status == GS_DIE_FLASHING)) begin
      state_q       <= ST_IDLE;
      busy_q        <= 1'b0;
      query_valid_q <= 1'b0;
      apple_valid_q <= 1'b1;
      tries_q       <= '0;
`ifdef APPLE_SPAWNER_SCAN_EN
      scan_q        <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (game_status == GS_PLAYING && get_apple) begin
            state_q       <= ST_DRAW;
            busy_q        <= 1'b1;
            apple_valid_q <= 1'b0;
          end
        end
        ST_DRAW: begin
          query_x_q     <= cand_x;
          query_y_q     <= cand_y;
          tries_q       <= tries_q + TRY_W'(1);
          query_valid_q <= 1'b1;
          state_q       <= ST_QUERY;
        end
        ST_QUERY: begin
          if (occ_valid) begin
            query_valid_q <= 1'b0;
            if (!occupied) begin
              state_q <= ST_COMMIT;
            end else if (tries_q < TRY_W'(MAX_TRIES)) begin
              state_q <= ST_DRAW;
`ifdef APPLE_SPAWNER_SCAN_EN
            end else if (scan_q != SCAN_W'(CELLS)) begin
              state_q <= ST_SCAN;
`endif
            end else begin
              state_q       <= ST_IDLE;
              busy_q        <= 1'b0;
              board_full_q  <= 1'b1;
              apple_valid_q <= 1'b0;
              tries_q       <= '0;
`ifdef APPLE_SPAWNER_SCAN_EN
              scan_q        <= '0;
`endif
            end
          end
        end
`ifdef APPLE_SPAWNER_SCAN_EN
        ST_SCAN: begin
          if (query_x_q == X_BITS'(X_MAX)) begin
            query_x_q <= X_BITS'(1);
            query_y_q <= (query_y_q == Y_BITS'(Y_MAX)) ? Y_BITS'(1)
                                                       : query_y_q + Y_BITS'(1);
          end else begin
            query_x_q <= query_x_q + X_BITS'(1);
          end
          scan_q        <= scan_q + SCAN_W'(1);
          query_valid_q <= 1'b1;
          state_q       <= ST_QUERY;
        end
`endif
        ST_COMMIT: begin
          apple_x_q     <= query_x_q;
          apple_y_q     <= query_y_q;
          apple_valid_q <= 1'b1;
          tries_q       <= '0;
`ifdef APPLE_SPAWNER_SCAN_EN
          scan_q        <= '0;
`endif
          state_q       <= ST_IDLE;
          busy_q        <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign query_valid = query_valid_q;
  assign query_x     = query_x_q;
  assign query_y     = query_y_q;
  assign apple_x     = apple_x_q;
  assign apple_y     = apple_y_q;
  assign apple_valid = apple_valid_q;
  assign busy        = busy_q;
  assign board_full  = board_full_q;

endmodule

`default_nettype wire

// File: tb/tb_apple_spawner.sv
//------------------------------------------------------------------
// tb_apple_spawner: table-driven spawns against an LFSR reference,
// plus INITIALIZING/abort sequences and a random soak.
// Rev 1.0
//------------------------------------------------------------------
`default_nettype none

module tb_apple_spawner;

  localparam int          XM   = 46;
  localparam int          YM   = 25;
  localparam int          MT   = 8;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam logic [1:0]  S_LAUNCH = 2'b00, S_PLAY = 2'b01, S_DIE = 2'b10, S_INIT = 2'b11;
`ifdef APPLE_SPAWNER_SCAN_EN
  localparam int FULL_Q  = MT + XM * YM;
  localparam int FULL_40 = 0;
`else
  localparam int FULL_Q  = MT;
  localparam int FULL_40 = -1;
`endif

  logic       clock = 1'b0;
  logic       reset_n;
  logic [1:0] game_status;
  logic       get_apple, occ_valid, occupied;
  logic       query_valid, apple_valid, busy, board_full;
  logic [5:0] query_x, apple_x;
  logic [4:0] query_y, apple_y;

  int total = 0;
  int bad   = 0;

  logic [15:0] m_lfsr, m_pre;

  apple_spawner dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .game_status (game_status),
    .get_apple   (get_apple),
    .query_valid (query_valid),
    .query_x     (query_x),
    .query_y     (query_y),
    .occ_valid   (occ_valid),
    .occupied    (occupied),
    .apple_x     (apple_x),
    .apple_y     (apple_y),
    .apple_valid (apple_valid),
    .busy        (busy),
    .board_full  (board_full)
  );

  always #5 clock = ~clock;

  // Reference LFSR; m_pre holds the value of the cycle just ended.
  always @(posedge clock) begin
    m_pre  <= m_lfsr;
    m_lfsr <= (!reset_n || game_status == S_INIT) ? SEED
            : ({1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000));
  end

  typedef struct {
    int thresh;      // cells with x < thresh answer occupied
    int delay;       // QUERY cycles before the response
    int exp_lat;     // edges after the get_apple edge until idle (-1: any)
    int exp_queries; // when nothing free is answered (-1: any)
    int exp_full;    // board_full afterwards (-1: any)
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  function automatic void red(input logic [15:0] s, output int x, output int y);
    x = int'(s[5:0]) + 1;
    if (x > XM) x -= XM;
    y = int'(s[12:8]) + 1;
    if (y > YM) y -= YM;
  endfunction

  function automatic void stp(input int px, input int py, output int x, output int y);
    if (px == XM) begin
      x = 1;
      y = (py == YM) ? 1 : py + 1;
    end else begin
      x = px + 1;
      y = py;
    end
  endfunction

  task automatic do_reset();
    reset_n = 1'b0; game_status = S_LAUNCH; get_apple = 1'b0;
    occ_valid = 1'b0; occupied = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic run_spawn(input vec_t v);
    int n, draws, queries, wait_cnt, ex, ey, px, py, fx, fy, old_x, old_y;
    bit qv_prev, have_free;
    old_x = int'(apple_x); old_y = int'(apple_y);
    n = 0; draws = 0; queries = 0; wait_cnt = 0; px = 0; py = 0; fx = 0; fy = 0;
    qv_prev = 1'b0; have_free = 1'b0;
    game_status = S_PLAY; get_apple = 1'b1;
    @(negedge clock);
    get_apple = 1'b0;
    chk("valid_drop", int'(apple_valid), 0);
    while (busy && n < 10000) begin
      occ_valid = 1'b0; occupied = 1'b0;
      if (query_valid) begin
        if (!qv_prev) begin
          queries++;
          if (draws < MT) begin
            draws++;
            red(m_pre, ex, ey);
          end else begin
            stp(px, py, ex, ey);
          end
          chk("cand_x", int'(query_x), ex);
          chk("cand_y", int'(query_y), ey);
          px = int'(query_x); py = int'(query_y);
          wait_cnt = v.delay;
        end else begin
          chk("query_stable", int'(query_x == px[5:0] && query_y == py[4:0]), 1);
        end
        if (wait_cnt == 0) begin
          occ_valid = 1'b1;
          occupied  = (int'(query_x) < v.thresh);
          if (!occupied) begin
            have_free = 1'b1; fx = int'(query_x); fy = int'(query_y);
          end
        end else begin
          wait_cnt--;
        end
      end
      qv_prev = query_valid;
      @(negedge clock);
      n++;
    end
    occ_valid = 1'b0; occupied = 1'b0;
    if (busy) begin
      total++; bad++;
      $display("FAIL spawn_timeout: busy still %0d after %0d cycles", busy, n);
      game_status = S_INIT;
      @(negedge clock);
      game_status = S_PLAY;
      return;
    end
    if (v.exp_lat >= 0) chk("latency", n, v.exp_lat);
    if (v.exp_full >= 0) chk("board_full", int'(board_full), v.exp_full);
    if (have_free) begin
      chk("apple_valid", int'(apple_valid), 1);
      chk("apple_x", int'(apple_x), fx);
      chk("apple_y", int'(apple_y), fy);
      chk("apple_x_ge_thresh", int'(int'(apple_x) >= v.thresh && apple_x <= XM), 1);
      chk("apple_y_range", int'(apple_y >= 1 && apple_y <= YM), 1);
    end else begin
      chk("full_queries", queries, (v.exp_queries >= 0) ? v.exp_queries : FULL_Q);
      chk("full_flag", int'(board_full), 1);
      chk("full_valid", int'(apple_valid), 0);
      chk("full_keep_x", int'(apple_x), old_x);
      chk("full_keep_y", int'(apple_y), old_y);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    int   x1, y1, ex, ey, ax, ay, r, lfx, lfy;
    logic [1:0] gs_applied;

    vecs[0] = '{thresh: 0,  delay: 0, exp_lat: 3,  exp_queries: 1,      exp_full: 0};
    vecs[1] = '{thresh: 0,  delay: 1, exp_lat: 4,  exp_queries: 1,      exp_full: 0};
    vecs[2] = '{thresh: 0,  delay: 3, exp_lat: 6,  exp_queries: 1,      exp_full: 0};
    vecs[3] = '{thresh: 40, delay: 0, exp_lat: -1, exp_queries: -1,     exp_full: FULL_40};
    vecs[4] = '{thresh: 40, delay: 2, exp_lat: -1, exp_queries: -1,     exp_full: FULL_40};
    vecs[5] = '{thresh: 20, delay: 1, exp_lat: -1, exp_queries: -1,     exp_full: FULL_40};
    vecs[6] = '{thresh: 99, delay: 0, exp_lat: -1, exp_queries: FULL_Q, exp_full: 1};
    vecs[7] = '{thresh: 0,  delay: 0, exp_lat: 3,  exp_queries: 1,      exp_full: 1};

    do_reset();
    chk("rst_apple_x", int'(apple_x), 20);
    chk("rst_apple_y", int'(apple_y), 13);
    chk("rst_valid", int'(apple_valid), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_qvalid", int'(query_valid), 0);
    chk("rst_query_xy", int'(query_x) + int'(query_y), 0);
    chk("rst_full", int'(board_full), 0);

    // get_apple outside PLAYING and stray occ_valid must not start a spawn
    get_apple = 1'b1; occ_valid = 1'b1;
    @(negedge clock);
    chk("ignore_busy", int'(busy), 0);
    chk("ignore_valid", int'(apple_valid), 1);
    get_apple = 1'b0; occ_valid = 1'b0;
    game_status = S_PLAY;
    @(negedge clock);

    for (int i = 0; i < 8; i++) begin
      run_spawn(vecs[i]);
      @(negedge clock);
    end

    // INITIALIZING mid-QUERY, then the same spawn timing must redraw the same cell
    do_reset();
    game_status = S_PLAY;
    repeat (4) @(negedge clock);
    get_apple = 1'b1;
    @(negedge clock);
    get_apple = 1'b0;
    @(negedge clock);
    chk("init_q_valid", int'(query_valid), 1);
    red(m_pre, ex, ey);
    chk("init_first_x", int'(query_x), ex);
    chk("init_first_y", int'(query_y), ey);
    x1 = int'(query_x); y1 = int'(query_y);
    game_status = S_INIT;
    @(negedge clock);
    chk("init_busy", int'(busy), 0);
    chk("init_qvalid", int'(query_valid), 0);
    chk("init_apple_x", int'(apple_x), 20);
    chk("init_apple_y", int'(apple_y), 13);
    chk("init_valid", int'(apple_valid), 1);
    chk("init_full", int'(board_full), 0);
    game_status = S_PLAY;
    repeat (4) @(negedge clock);
    get_apple = 1'b1;
    @(negedge clock);
    get_apple = 1'b0;
    @(negedge clock);
    chk("repeat_q_valid", int'(query_valid), 1);
    chk("repeat_x", int'(query_x), x1);
    chk("repeat_y", int'(query_y), y1);

    // DIE_FLASHING while busy aborts and keeps the old apple
    game_status = S_DIE;
    @(negedge clock);
    chk("abort_busy", int'(busy), 0);
    chk("abort_qvalid", int'(query_valid), 0);
    chk("abort_valid", int'(apple_valid), 1);
    chk("abort_apple", int'(apple_x == 6'd20 && apple_y == 5'd13), 1);

    // Random soak: every apple change must be INIT or the last cell answered free
    ax = int'(apple_x); ay = int'(apple_y); lfx = 0; lfy = 0;
    gs_applied = game_status;
    for (int c = 0; c < 3000; c++) begin
      if (int'(apple_x) != ax || int'(apple_y) != ay) begin
        if (gs_applied == S_INIT) begin
          chk("soak_init_xy", int'(apple_x == 6'd20 && apple_y == 5'd13), 1);
        end else begin
          chk("soak_x", int'(apple_x), lfx);
          chk("soak_y", int'(apple_y), lfy);
          chk("soak_range", int'(apple_x >= 1 && apple_x <= XM &&
                                  apple_y >= 1 && apple_y <= YM), 1);
        end
      end
      ax = int'(apple_x); ay = int'(apple_y);
      r = int'($urandom_range(0, 99));
      game_status = (r < 85) ? S_PLAY : (r < 90) ? S_LAUNCH : (r < 95) ? S_DIE : S_INIT;
      get_apple = ($urandom_range(0, 3) == 0);
      occ_valid = $urandom_range(0, 1) == 1;
      occupied  = $urandom_range(0, 2) == 0;
      if (query_valid && occ_valid && !occupied) begin
        lfx = int'(query_x); lfy = int'(query_y);
      end
      gs_applied = game_status;
      @(negedge clock);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
